// File: rtl/data_bus_ctrl.sv
// Data-side bus controller between the MEM stage and a req/ack memory bus.
// Issues one registered transaction per aligned access and stalls MEM meanwhile.
module data_bus_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic        flush_i,
    output logic [31:0] rdata_o,
    output logic        stallreq_o,
    output logic        excp_adel_o,
    output logic        excp_ades_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        DRAIN
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic aligned;
    logic expire;

    assign aligned     = (mem_addr_i[1:0] == 2'b00);
    assign expire      = (cnt_q == CNT_LAST);
    assign excp_adel_o = mem_ce_i && !aligned && !mem_we_i;
    assign excp_ades_o = mem_ce_i && !aligned && mem_we_i;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
        cnt_d      = cnt_q;
        stallreq_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_ce_i && aligned && !flush_i) begin
                    stallreq_o = 1'b1;
                    req_d      = 1'b1;
                    we_d       = mem_we_i;
                    addr_d     = {mem_addr_i[31:2], 2'b00};
                    wdata_d    = mem_data_i;
                    cnt_d      = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                stallreq_o = !flush_i;
                if (bus_ack_i || expire) begin
                    req_d = 1'b0;
                    // A flush racing completion leaves nothing to deliver.
                    if (flush_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                        if (bus_ack_i) begin
                            if (!we_q) rdata_d = bus_rdata_i;
                        end else begin
                            rdata_d = '0;
                            err_d   = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (flush_i) state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            DRAIN: begin
                stallreq_o = mem_ce_i && !flush_i;
                if (bus_ack_i || expire) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rdata_o     = rdata_q;
    assign bus_err_o   = err_q;
    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;

endmodule
